// File: rtl/layer_compositor.sv
// Priority compositor of NUM_LAYERS overlays over a background, with the VGA timing delayed to stay aligned with the pixel.
// Optional macro COMPOSITOR_BLINK_EN gates layer 0 with frame_cnt[BLINK_BIT] so the cursor blinks.
module layer_compositor #(
    parameter int NUM_LAYERS      = 4,
    parameter int LATENCY         = 2,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int FRAME_CNT_W     = 8,
    parameter int BLINK_BIT       = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [10:0]              hcount_in,
    input  logic [9:0]               vcount_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     blank_in,
    input  logic [12*NUM_LAYERS-1:0] layer_pix_in,
    input  logic [NUM_LAYERS-1:0]    layer_valid_in,
    input  logic [NUM_LAYERS-1:0]    layer_en_in,
    input  logic [11:0]              bg_pix_in,
    output logic [11:0]              pix_out,
    output logic [10:0]              hcount_out,
    output logic [9:0]               vcount_out,
    output logic                     hsync_out,
    output logic                     vsync_out,
    output logic                     blank_out,
    output logic [FRAME_CNT_W-1:0]   frame_cnt_out
);
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || LATENCY < 2 || BLINK_BIT >= FRAME_CNT_W) begin : g_param_err
        $error("layer_compositor: illegal parameter combination");
    end

    logic                   vs_prev_q;
    logic                   vs_edge;
    logic [NUM_LAYERS-1:0]  shadow_q, shadow_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [NUM_LAYERS-1:0]  layer_ok;
    logic [11:0]            comp_d;

    // Edge = vsync newly at its asserted level; the previous sample idles inactive so the first edge after reset counts.
    assign vs_edge = (vsync_in != SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);

    always_comb begin
        shadow_d    = shadow_q;
        frame_cnt_d = frame_cnt_q;
        if (vs_edge) begin
            shadow_d    = layer_en_in;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vs_prev_q   <= SYNC_IDLE;
            shadow_q    <= '1;
            frame_cnt_q <= '0;
        end else begin
            vs_prev_q   <= vsync_in;
            shadow_q    <= shadow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // The pixel on the edge cycle still sees the old shadow, since shadow_q only updates at the end of it.
    always_comb begin
        layer_ok = layer_valid_in & shadow_q;
`ifdef COMPOSITOR_BLINK_EN
        layer_ok[0] = layer_ok[0] & ~frame_cnt_q[BLINK_BIT];
`endif
        comp_d = bg_pix_in;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_ok[i]) begin
                comp_d = layer_pix_in[12*i +: 12];
            end
        end
        if (blank_in) begin
            comp_d = 12'h000;
        end
    end

    logic [11:0] pix_q    [LATENCY];
    logic [10:0] hcount_q [LATENCY];
    logic [9:0]  vcount_q [LATENCY];
    logic        hsync_q  [LATENCY];
    logic        vsync_q  [LATENCY];
    logic        blank_q  [LATENCY];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < LATENCY; i++) begin
                pix_q[i]    <= 12'h000;
                hcount_q[i] <= 11'd0;
                vcount_q[i] <= 10'd0;
                hsync_q[i]  <= SYNC_IDLE;
                vsync_q[i]  <= SYNC_IDLE;
                blank_q[i]  <= 1'b1;
            end
        end else begin
            pix_q[0]    <= comp_d;
            hcount_q[0] <= hcount_in;
            vcount_q[0] <= vcount_in;
            hsync_q[0]  <= hsync_in;
            vsync_q[0]  <= vsync_in;
            blank_q[0]  <= blank_in;
            for (int i = 1; i < LATENCY; i++) begin
                pix_q[i]    <= pix_q[i-1];
                hcount_q[i] <= hcount_q[i-1];
                vcount_q[i] <= vcount_q[i-1];
                hsync_q[i]  <= hsync_q[i-1];
                vsync_q[i]  <= vsync_q[i-1];
                blank_q[i]  <= blank_q[i-1];
            end
        end
    end

    assign pix_out       = pix_q[LATENCY-1];
    assign hcount_out    = hcount_q[LATENCY-1];
    assign vcount_out    = vcount_q[LATENCY-1];
    assign hsync_out     = hsync_q[LATENCY-1];
    assign vsync_out     = vsync_q[LATENCY-1];
    assign blank_out     = blank_q[LATENCY-1];
    assign frame_cnt_out = frame_cnt_q;
endmodule
